// File: rtl/mem_pkg.sv
// Shared types and defaults for the load/store front end and the `ram` block it drives.
// Pure declarations; no timing or flow-control behaviour of its own.
package mem_pkg;

  localparam int DEF_WORD       = 4;
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LD_WAIT   = 2'd1,
    ST_RMW_WRITE = 2'd2,
    ST_RESP      = 2'd3
  } mau_state_t;

  typedef struct packed {
    logic      store;
    mem_size_t size;
    logic      is_signed;
  } req_ctl_t;

  // Encoding 3 is folded into a word access.
  function automatic mem_size_t decode_size(input logic [1:0] raw);
    mem_size_t sz;
    case (raw)
      2'd0:    sz = MEM_BYTE;
      2'd1:    sz = MEM_HALF;
      default: sz = MEM_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input mem_size_t sz, input logic [1:0] lo);
    logic mis;
    case (sz)
      MEM_HALF: mis = lo[0];
      MEM_WORD: mis = |lo;
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the low byte/half/word of a load and sign- or zero-extends it.
// Purely combinational, zero latency, no flow control.
module load_extend
  import mem_pkg::*;
#(
  parameter int WORD  = DEF_WORD,
  parameter int WIDTH = DEF_WIDTH
) (
  input  mem_size_t                 size,
  input  logic                      is_signed,
  input  logic [WORD*WIDTH-1:0]     raw,
  output logic [WORD*WIDTH-1:0]     ext
);

  localparam int DW = WORD * WIDTH;
  localparam int HW = 2 * WIDTH;

  always_comb begin
    ext = raw;
    case (size)
      MEM_BYTE: ext = {{(DW - WIDTH){is_signed & raw[WIDTH-1]}}, raw[WIDTH-1:0]};
      MEM_HALF: ext = {{(DW - HW){is_signed & raw[HW-1]}}, raw[HW-1:0]};
      default:  ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for `ram`: sub-word loads with extension, sub-word stores via read-modify-write.
// Latency 1 (word store) or 2 cycles; one request in flight, req_ready only in IDLE. Option: MEM_ALIGN_CHECK_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int WORD       = DEF_WORD,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [WORD*WIDTH-1:0] req_addr,
  input  logic [WORD*WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [WORD*WIDTH-1:0] rsp_rdata,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                  rsp_misaligned,
`endif
  output logic [WORD*WIDTH-1:0] ram_d,
  output logic [WORD*WIDTH-1:0] ram_ad,
  output logic                  ram_we,
  input  logic [WORD*WIDTH-1:0] ram_q
);

  localparam int DW = WORD * WIDTH;
  localparam int HW = 2 * WIDTH;

  // The full address goes to `ram`, which decodes only its low ADDR_WIDTH bits.
  if (ADDR_WIDTH > DW) begin : g_addr_width_check
    $error("ADDR_WIDTH wider than the address bus");
  end

  mau_state_t    state_q, state_d;
  req_ctl_t      ctl_q, ctl_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] ld_ext;
  mem_size_t     size_dec;
  logic          accept;
  logic          mis_req;
  logic          mis_q, mis_d;

  assign size_dec = decode_size(req_size);
  assign accept   = rst_n & req_valid & (state_q == ST_IDLE);

`ifdef MEM_ALIGN_CHECK_EN
  assign mis_req        = is_misaligned(size_dec, req_addr[1:0]);
  assign rsp_misaligned = mis_q & (state_q == ST_RESP);
`else
  assign mis_req = 1'b0;
`endif

  load_extend #(.WORD(WORD), .WIDTH(WIDTH)) u_load_extend (
    .size      (ctl_q.size),
    .is_signed (ctl_q.is_signed),
    .raw       (ram_q),
    .ext       (ld_ext)
  );

  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    ram_we  = 1'b0;
    ram_ad  = addr_q;
    ram_d   = wdata_q;

    case (state_q)
      ST_IDLE: begin
        // Drive the request straight through so the read starts in the accept cycle.
        ram_ad = req_addr;
        ram_d  = req_wdata;
        if (accept) begin
          ctl_d   = '{store: req_store, size: size_dec, is_signed: req_signed};
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          mis_d   = mis_req;
          if (mis_req) begin
            state_d = ST_RESP;
          end else if (req_store && size_dec == MEM_WORD) begin
            ram_we  = 1'b1;
            state_d = ST_RESP;
          end else if (req_store) begin
            state_d = ST_RMW_WRITE;
          end else begin
            state_d = ST_LD_WAIT;
          end
        end
      end
      ST_LD_WAIT: begin
        rdata_d = ld_ext;
        state_d = ST_RESP;
      end
      ST_RMW_WRITE: begin
        ram_we = 1'b1;
        if (ctl_q.size == MEM_BYTE) begin
          ram_d = {ram_q[DW-1:WIDTH], wdata_q[WIDTH-1:0]};
        end else begin
          ram_d = {ram_q[DW-1:HW], wdata_q[HW-1:0]};
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A reset landing on an RMW cycle must not commit the half-built word.
    if (!rst_n) begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a byte-addressed word RAM model with registered read.
// Define MEM_ALIGN_CHECK_EN to also cover the misalignment path.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
`ifdef MEM_ALIGN_CHECK_EN
  logic        rsp_misaligned;
`endif
  logic [31:0] ram_d;
  logic [31:0] ram_ad;
  logic        ram_we;
  logic [31:0] ram_q;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:1023];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
`ifdef MEM_ALIGN_CHECK_EN
    .rsp_misaligned (rsp_misaligned),
`endif
    .ram_d      (ram_d),
    .ram_ad     (ram_ad),
    .ram_we     (ram_we),
    .ram_q      (ram_q)
  );

  // RAM model: whole-word write at any byte address, read data registered.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we) mem[10'(ram_ad[9:0] + 10'(i))] <= ram_d[8*i +: 8];
      ram_q[8*i +: 8] <= mem[10'(ram_ad[9:0] + 10'(i))];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic st, input logic [1:0] sz, input logic sg,
                     input logic [31:0] ad, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output int we_cnt,
                     output int pulses, output logic mis);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    lat = -1; rd = '0; we_cnt = 0; pulses = 0; mis = 1'b0;
    #1;
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    if (ram_we) we_cnt++;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      if (ram_we) we_cnt++;
      if (rsp_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          rd  = rsp_rdata;
`ifdef MEM_ALIGN_CHECK_EN
          mis = rsp_misaligned;
`endif
        end
      end
    end
  endtask

  task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] ad,
                          input logic [31:0] wd, input int exp_lat);
    int lat, we, pu;
    logic [31:0] rd;
    logic mis;
    txn(1'b1, sz, 1'b0, ad, wd, lat, rd, we, pu, mis);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_we"}, 32'(we), 32'd1);
    check({tag, "_rdata"}, rd, 32'd0);
    check({tag, "_pulses"}, 32'(pu), 32'd1);
`ifdef MEM_ALIGN_CHECK_EN
    check({tag, "_mis"}, {31'd0, mis}, 32'd0);
`endif
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] exp);
    int lat, we, pu;
    logic [31:0] rd;
    logic mis;
    txn(1'b0, sz, sg, ad, 32'h0, lat, rd, we, pu, mis);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_rdata"}, rd, exp);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_pulses"}, 32'(pu), 32'd1);
`ifdef MEM_ALIGN_CHECK_EN
    check({tag, "_mis"}, {31'd0, mis}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, pulses, notrdy, rst_pulses, rst_we;
    int acc_c [3];

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    req_addr = 32'h0000_0440; #1;
    check("idle_ram_ad", ram_ad, 32'h0000_0440);

    // Word store / load, then sub-word RMW
    do_store("st_w10", 2'd2, 32'h10, 32'hDEADBEEF, 1);
    do_load ("ld_w10", 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    do_store("st_b11", 2'd0, 32'h11, 32'h000000A5, 2);
    do_load ("ld_w10b", 2'd2, 1'b0, 32'h10, 32'hDEADA5EF);
    do_load ("ld_b11s", 2'd0, 1'b1, 32'h11, 32'hFFFFFFA5);
    do_load ("ld_b11u", 2'd0, 1'b0, 32'h11, 32'h000000A5);
    do_store("st_h12", 2'd1, 32'h12, 32'h12348001, 2);
    do_load ("ld_h12s", 2'd1, 1'b1, 32'h12, 32'hFFFF8001);
    do_load ("ld_h12u", 2'd1, 1'b0, 32'h12, 32'h00008001);
    do_load ("ld_w10c", 2'd2, 1'b1, 32'h10, 32'h8001A5EF);
    do_load ("ld_b10s", 2'd0, 1'b1, 32'h10, 32'hFFFFFFEF);
    do_store("st_sz3", 2'd3, 32'h30, 32'hCAFEF00D, 1);
    do_load ("ld_sz3", 2'd3, 1'b1, 32'h30, 32'hCAFEF00D);

`ifdef MEM_ALIGN_CHECK_EN
    begin
      int lat, we, pu;
      logic [31:0] rd;
      logic mis;
      txn(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, lat, rd, we, pu, mis);
      check("mis_ld_lat", 32'(lat), 32'd1);
      check("mis_ld_flag", {31'd0, mis}, 32'd1);
      check("mis_ld_rdata", rd, 32'd0);
      txn(1'b1, 2'd2, 1'b0, 32'h13, 32'hFFFFFFFF, lat, rd, we, pu, mis);
      check("mis_st_we", 32'(we), 32'd0);
      check("mis_st_flag", {31'd0, mis}, 32'd1);
      check("mis_st_lat", 32'(lat), 32'd1);
      do_load("ld_w10_after_mis", 2'd2, 1'b0, 32'h10, 32'h8001A5EF);
    end
`else
    do_load("ld_w13_unal", 2'd2, 1'b0, 32'h13, 32'h00000080);
`endif

    // Back-to-back: request held high across three loads
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h10;
    acc = 0; pulses = 0; notrdy = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (rsp_valid) pulses++;
      if (req_valid && req_ready) begin
        if (acc < 3) acc_c[acc] = c;
        acc++;
      end else if (req_valid) begin
        notrdy++;
      end
      @(posedge clk);
      #1;
      if (acc == 3) req_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_accepts", 32'(acc), 32'd3);
    check("b2b_gap1", 32'(acc_c[1] - acc_c[0]), 32'd3);
    check("b2b_gap2", 32'(acc_c[2] - acc_c[1]), 32'd3);
    check("b2b_pulses", 32'(pulses), 32'd3);
    check("b2b_not_ready", 32'(notrdy), 32'd4);

    // Reset in the middle of a byte RMW
    do_store("st_w20", 2'd2, 32'h20, 32'h11223344, 1);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h00000099;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rmw_rst_we", {31'd0, ram_we}, 32'd0);
    rst_pulses = 0; rst_we = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid) rst_pulses++;
      if (ram_we) rst_we++;
    end
    check("rmw_rst_pulses", 32'(rst_pulses), 32'd0);
    check("rmw_rst_we_cycles", 32'(rst_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rmw_rst_rdata", rsp_rdata, 32'd0);
    check("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
    do_load("ld_w20", 2'd2, 1'b0, 32'h20, 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end sitting directly upstream of the byte-addressed BRAM `ram` block; the CPU memory stage issues requests here instead of to `ram` directly.
- Adds byte/halfword loads with sign or zero extension.
- `ram` writes only whole words, so byte/halfword stores are done as read-modify-write.
- Single outstanding request; valid/ready request side, one-cycle response pulse.

Parameters:
- WORD, 4, bytes per word (must match `ram`)
- WIDTH, 8, bits per byte (must match `ram`)
- ADDR_WIDTH, 10, byte-address bits used by `ram`

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept (high only in IDLE)
- req_store  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- req_signed  in  1  sign-extend load result
- req_addr  in  WORD*WIDTH  byte address
- req_wdata  in  WORD*WIDTH  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  WORD*WIDTH  extended load data (0 for stores)
- ram_d  out  WORD*WIDTH  to `ram` d
- ram_ad  out  WORD*WIDTH  to `ram` ad
- ram_we  out  1  to `ram` we
- ram_q  in  WORD*WIDTH  from `ram` q (registered, 1-cycle latency)

Behaviour:
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, ram_we 0, latched address/data/size 0. req_ready=1 from the first cycle after reset.
- Byte order is little-endian; the byte at ram_ad is ram_q[7:0]. `ram` returns a word at any byte address, so no lane shifting is needed.
- Handshake:
  - accept when req_valid & req_ready (cycle T); latch store/size/signed/addr/wdata.
  - In IDLE, ram_ad = req_addr combinationally, so the read starts in cycle T.
  - Outside IDLE, ram_ad = latched address.
- FSM states: IDLE, LD_WAIT, RMW_WRITE, RESP.
- IDLE transitions on accept:
  - word store → ram_we=1 and ram_d=req_wdata in cycle T → RESP.
  - byte/half store → RMW_WRITE.
  - load → LD_WAIT.
- LD_WAIT (T+1): ram_q is valid this cycle. Extract low 8/16/32 bits, then sign- or zero-extend into rsp_rdata (registered) → RESP.
- RMW_WRITE (T+1):
  - byte: ram_d = {ram_q[31:8], wdata[7:0]}
  - half: ram_d = {ram_q[31:16], wdata[15:0]}
  - ram_we=1 → RESP.
- RESP: rsp_valid=1 for exactly one cycle → IDLE. req_ready=0 in this state.
- Latency, acceptance to rsp_valid:
  - word store: 1 cycle.
  - load, sub-word store: 2 cycles.
  - Next accept is possible the cycle after RESP.
- ram_we is combinational from state/request and is never high outside the cycles above.
- Address wrap: only ad[ADDR_WIDTH-1:0] is significant in `ram`. The unit passes the full address unchanged and does not wrap.
- Reset mid-operation: state returns to IDLE on the reset edge. A pending RMW write or response is dropped, and ram_we is 0 in every reset cycle. Memory keeps whatever was already written.
- req_valid held with no accept (not IDLE): no effect. The requester holds the request stable until accepted.
- Store response: rsp_rdata = 0.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- With it:
  - extra output rsp_misaligned (1 bit, reset 0).
  - A half access with addr[0]≠0, or a word access with addr[1:0]≠0, is accepted but issues no ram_we.
  - It goes straight to RESP and pulses rsp_valid with rsp_misaligned=1 and rsp_rdata=0 (latency 1).
- Without it: the port is absent and unaligned accesses proceed normally.

Decomposition:
- Shared package mem_pkg:
  - enum mem_size_t {MEM_BYTE, MEM_HALF, MEM_WORD}
  - enum mau_state_t for the FSM states
  - localparam defaults WORD/WIDTH/ADDR_WIDTH shared with `ram`
- One natural sub-module, load_extend: combinational size select plus sign/zero extension. It is reused by the LD_WAIT path and by future writeback muxing.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 → store rsp at T+1, ram_we high 1 cycle; load rsp at T+2 with rdata 0xDEADBEEF.
- After the above, byte store 0xA5 @0x11, then word load @0x10 → 0xDEADA5EF; ram_we high only in the RMW_WRITE cycle.
- Byte load @0x11: signed → 0xFFFFFFA5, unsigned → 0x000000A5. Half store 0x8001 @0x12, then signed half load @0x12 → 0xFFFF8001.
- Back-to-back req_valid held high for 3 loads → req_ready low in LD_WAIT/RESP; accepts are 3 cycles apart; exactly 3 rsp_valid pulses.
- rst_n low during RMW_WRITE of a byte store @0x20 (prior word 0x11223344) → ram_we 0, no rsp_valid; after reset, word load @0x20 returns 0x11223344.
- (MEM_ALIGN_CHECK_EN) word load @0x13 → rsp_valid at T+1 with rsp_misaligned=1, rdata 0; a word store @0x13 → ram_we never asserted.
